bot_step_sequencer: RTL and testbench
=====================================

# bot_step_sequencer

Synthesisable, parametrised replacement for the hand-sequenced update → collision-detect → velocity-select flow of the multi-robot simulator. It holds the state of `N_BOTS` robots in an internal register file and advances all of them by one Euler step per `start`. It then runs an all-pairs collision sweep on the new positions and reverses the velocity of every collided robot. All data is signed fixed point with `FRAC` fractional bits, the same format used by the existing update and collision modules.

## Interface
Parameters:
- `N_BOTS`, 4: number of robots, ≥ 2.
- `W`, 16: signed data width of position, velocity and acceleration.
- `FRAC`, 11: fractional bits (1.0 = 2048).
- `T_STEP`, 2048: time step, Q(W-FRAC).FRAC.

Ports (`IW` = `$clog2(N_BOTS)`):
- `clock` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `load_valid` in 1: write one robot state.
- `load_ready` out 1: high only in IDLE and only when `start` = 0.
- `load_id` in IW: index of the robot to write.
- `load_x`, `load_y`, `load_vx`, `load_vy` in W each: initial state for that robot.
- `acc_ax`, `acc_ay` in W: global acceleration, sampled when `start` is accepted.
- `radius_sq` in 2W+2: collision threshold; scale is 2·FRAC fractional bits. Sampled at `start`.
- `start` in 1: begin one step; ignored unless in IDLE.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at the end of a step.
- `coll_flag` out N_BOTS: bit i set if robot i collided during the last step.
- `rd_id` in IW: combinational read index.
- `rd_x`, `rd_y`, `rd_vx`, `rd_vy` out W: state of robot `rd_id`.

## Operation
- **States:** IDLE → UPDATE → COLLIDE → RESOLVE → DONE → IDLE.
- **IDLE**
  - A load is performed when `load_valid` and `load_ready` are both high.
  - When `start` is high: latch `acc_ax`, `acc_ay` and `radius_sq`, clear `coll_flag`, then go to UPDATE.
  - If `start` and `load_valid` are high in the same cycle, `start` wins and the load is not performed.
- **UPDATE:** one robot per cycle, index 0 to N_BOTS-1.
  - x' = sat(x + ((vx·T_STEP) >>> FRAC)).
  - vx' = sat(vx + ((ax·T_STEP) >>> FRAC)).
  - y and vy are updated the same way.
  - The position update uses the old velocity.
  - Products are 2W bits; `>>>` is an arithmetic shift (truncates toward −∞). `sat` clamps to [−2^(W−1), 2^(W−1)−1].
- **COLLIDE:** one pair (i, j), i < j, per cycle, using the updated positions.
  - Order: (0,1), (0,2) … (0,N−1), (1,2) … (N−2,N−1).
  - Total P = N_BOTS·(N_BOTS−1)/2 cycles.
  - dx and dy are computed at W+1 bits. dsq = dx² + dy², computed at 2W+2 bits, unsigned.
  - If dsq < `radius_sq` (strict), set `coll_flag[i]` and `coll_flag[j]`.
- **RESOLVE:** one cycle. Every flagged robot gets vx ← sat(−vx) and vy ← sat(−vy), so −2^(W−1) maps to 2^(W−1)−1. A robot flagged in several pairs is negated exactly once.
- **DONE:** `done` = 1 for one cycle; `coll_flag` holds until the next accepted `start`.
- **Reset:** clears all robot state and `coll_flag` to 0 and forces IDLE. Every output resets to 0 except `load_ready`, which reads 1 after reset whenever `start` = 0. This holds even if reset arrives mid-step; no partial step survives.

## Timing
- `start` is sampled at edge E0.
  - UPDATE occupies E1…E_N.
  - COLLIDE occupies E_N+1…E_N+P.
  - RESOLVE is at E_N+P+1.
  - `done` is high from E_N+P+2 to E_N+P+3.
- Total latency is N+P+2 cycles; for N_BOTS = 4 this is 12.
- `busy` rises at E0+ and falls at E_N+P+3.
- `rd_*` are combinational from the register file. Mid-step reads are allowed but return values that are in flight.
- A load becomes visible on `rd_*` in the cycle after it is accepted.
- A `start` held high through DONE is accepted again in the cycle after the return to IDLE. Back-to-back steps therefore have a one-cycle IDLE gap.

## Structure
- **Shared package `bot_pkg`:** `FRAC` and `W` defaults, the state enum (IDLE/UPDATE/COLLIDE/RESOLVE/DONE), and the `sat` function.
- **Sub-module `bot_euler_step`:** purely combinational, (p, v, a, T) → (p', v'), instantiated twice for the x and y axes.
- **Kept in the top module:** pair counters, squared-distance compare and FSM.

## Test plan
- **Basic step:** load robot 0 with x = 0, vx = 1024; ax = 1024; start → x = 1024, vx = 2048, `done` at cycle 12, `coll_flag` = 0.
- **Saturation:** x = 32000, vx = 16384 → x = 32767. vx = 32000 with ax = 2048 → vx = 32767.
- **Collision:**
  - Setup: robot 0 at (0,0) with v = (100, 0); robot 1 at (205,0) with v = (100, 0); robots 2 and 3 far apart; ax = ay = 0; `radius_sq` = 202500.
  - After update, robot 0 is at (100,0) and robot 1 at (305,0), so dsq = 42025 < 202500.
  - Expected: `coll_flag` = 4'b0011, both vx = −100; robots 2 and 3 unchanged.
- **Boundary compare:** dsq exactly equal to `radius_sq` → no collision. A robot in two colliding pairs has its velocity negated once. vx = −32768 colliding → 32767.
- **Handshake:** `load_valid` held during `busy` → `load_ready` = 0 and no write. `start` and `load_valid` in the same IDLE cycle → step runs, load dropped. `start` pulsed while busy → ignored.
- **Reset mid-operation:** assert `rst_n` = 0 during COLLIDE → state IDLE immediately, all `rd_*` = 0, `coll_flag` = 0, `done` never pulses.

Source files
------------

// File: rtl/bot_pkg.sv
// Shared types and helpers for the robot step sequencer.
package bot_pkg;

  localparam int unsigned DefaultW    = 16;
  localparam int unsigned DefaultFrac = 11;

  typedef enum logic [2:0] {
    StIdle,
    StUpdate,
    StCollide,
    StResolve,
    StDone
  } state_t;

  // Clamp a wide signed value into the signed range of a w-bit word (w <= 63).
  function automatic logic signed [63:0] sat(input logic signed [63:0] val,
                                             input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (val > hi) begin
      return hi;
    end else if (val < lo) begin
      return lo;
    end
    return val;
  endfunction

endpackage

// File: rtl/bot_step_sequencer_if.sv
// Load, control, status and read-port bundle of the robot step sequencer.
interface bot_step_sequencer_if #(
  parameter int unsigned N_BOTS = 4,
  parameter int unsigned W      = 16
);
  localparam int unsigned IW = $clog2(N_BOTS);

  logic                    load_valid;
  logic                    load_ready;
  logic [IW-1:0]           load_id;
  logic signed [W-1:0]     load_x;
  logic signed [W-1:0]     load_y;
  logic signed [W-1:0]     load_vx;
  logic signed [W-1:0]     load_vy;
  logic signed [W-1:0]     acc_ax;
  logic signed [W-1:0]     acc_ay;
  logic [2*W+1:0]          radius_sq;
  logic                    start;
  logic                    busy;
  logic                    done;
  logic [N_BOTS-1:0]       coll_flag;
  logic [IW-1:0]           rd_id;
  logic signed [W-1:0]     rd_x;
  logic signed [W-1:0]     rd_y;
  logic signed [W-1:0]     rd_vx;
  logic signed [W-1:0]     rd_vy;

  modport master (
    output load_valid, load_id, load_x, load_y, load_vx, load_vy,
    output acc_ax, acc_ay, radius_sq, start, rd_id,
    input  load_ready, busy, done, coll_flag, rd_x, rd_y, rd_vx, rd_vy
  );

  modport slave (
    input  load_valid, load_id, load_x, load_y, load_vx, load_vy,
    input  acc_ax, acc_ay, radius_sq, start, rd_id,
    output load_ready, busy, done, coll_flag, rd_x, rd_y, rd_vx, rd_vy
  );
endinterface

// File: rtl/bot_euler_step.sv
// One-axis explicit Euler step: p' = sat(p + v*T), v' = sat(v + a*T), fixed point.
module bot_euler_step import bot_pkg::*; #(
  parameter int unsigned W      = DefaultW,
  parameter int unsigned FRAC   = DefaultFrac,
  parameter int          T_STEP = 2048
) (
  input  logic signed [W-1:0] p,
  input  logic signed [W-1:0] v,
  input  logic signed [W-1:0] a,
  output logic signed [W-1:0] p_next,
  output logic signed [W-1:0] v_next
);

  localparam logic signed [2*W-1:0] TStep = (2*W)'(T_STEP);

  logic signed [2*W-1:0] dp;
  logic signed [2*W-1:0] dv;
  logic signed [63:0]    p_sum;
  logic signed [63:0]    v_sum;

  // Scale by the time step, drop the fraction (floor), then add with saturation.
  always_comb begin
    dp     = $signed({{W{v[W-1]}}, v}) * TStep;
    dv     = $signed({{W{a[W-1]}}, a}) * TStep;
    dp     = dp >>> FRAC;
    dv     = dv >>> FRAC;
    p_sum  = 64'(p) + 64'(dp);
    v_sum  = 64'(v) + 64'(dv);
    p_next = W'(sat(p_sum, W));
    v_next = W'(sat(v_sum, W));
  end

endmodule

// File: rtl/bot_step_sequencer.sv
// Advances N_BOTS robots by one Euler step, sweeps all pairs for collisions and
// reverses the velocity of every robot that collided.
module bot_step_sequencer import bot_pkg::*; #(
  parameter int unsigned N_BOTS = 4,
  parameter int unsigned W      = DefaultW,
  parameter int unsigned FRAC   = DefaultFrac,
  parameter int          T_STEP = 2048
) (
  input logic                 clock,
  input logic                 rst_n,
  bot_step_sequencer_if.slave bus
);

  localparam int unsigned IW = $clog2(N_BOTS);

  state_t              state_q;
  logic [IW-1:0]       idx_q;
  logic [IW-1:0]       pi_q;
  logic [IW-1:0]       pj_q;
  logic signed [W-1:0] x_q  [N_BOTS];
  logic signed [W-1:0] y_q  [N_BOTS];
  logic signed [W-1:0] vx_q [N_BOTS];
  logic signed [W-1:0] vy_q [N_BOTS];
  logic signed [W-1:0] ax_q;
  logic signed [W-1:0] ay_q;
  logic [2*W+1:0]      radius_q;
  logic [N_BOTS-1:0]   flag_q;
  logic                busy_q;
  logic                done_q;

  logic signed [W-1:0] nx, nvx, ny, nvy;
  logic signed [W:0]   dx, dy;
  logic [2*W+1:0]      dsq;
  logic                hit;
  logic                idle;
  logic                accept;
  logic                load_fire;

  bot_euler_step #(.W(W), .FRAC(FRAC), .T_STEP(T_STEP)) u_step_x (
    .p      (x_q[idx_q]),
    .v      (vx_q[idx_q]),
    .a      (ax_q),
    .p_next (nx),
    .v_next (nvx)
  );

  bot_euler_step #(.W(W), .FRAC(FRAC), .T_STEP(T_STEP)) u_step_y (
    .p      (y_q[idx_q]),
    .v      (vy_q[idx_q]),
    .a      (ay_q),
    .p_next (ny),
    .v_next (nvy)
  );

  // Squared distance of the current pair at full precision, strict compare.
  always_comb begin
    dx  = (W+1)'(x_q[pi_q]) - (W+1)'(x_q[pj_q]);
    dy  = (W+1)'(y_q[pi_q]) - (W+1)'(y_q[pj_q]);
    dsq = $unsigned((2*W+2)'(dx) * (2*W+2)'(dx) + (2*W+2)'(dy) * (2*W+2)'(dy));
    hit = dsq < radius_q;
  end

  // busy_q stays high for one cycle after DONE, so IDLE is only "open" once it drops.
  always_comb begin
    idle           = (state_q == StIdle) && !busy_q;
    accept         = idle && bus.start;
    bus.load_ready = idle && !bus.start;
    load_fire      = bus.load_valid && bus.load_ready;
  end

  // Combinational read port and registered status outputs.
  always_comb begin
    bus.rd_x      = x_q[bus.rd_id];
    bus.rd_y      = y_q[bus.rd_id];
    bus.rd_vx     = vx_q[bus.rd_id];
    bus.rd_vy     = vy_q[bus.rd_id];
    bus.busy      = busy_q;
    bus.done      = done_q;
    bus.coll_flag = flag_q;
  end

  // Step FSM together with the register file it sequences.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      pi_q     <= '0;
      pj_q     <= '0;
      ax_q     <= '0;
      ay_q     <= '0;
      radius_q <= '0;
      flag_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < N_BOTS; i++) begin
        x_q[i]  <= '0;
        y_q[i]  <= '0;
        vx_q[i] <= '0;
        vy_q[i] <= '0;
      end
    end else begin
      done_q <= (state_q == StDone);
      busy_q <= (state_q != StIdle) || accept;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            ax_q     <= bus.acc_ax;
            ay_q     <= bus.acc_ay;
            radius_q <= bus.radius_sq;
            flag_q   <= '0;
            idx_q    <= '0;
            state_q  <= StUpdate;
          end else if (load_fire) begin
            x_q[bus.load_id]  <= bus.load_x;
            y_q[bus.load_id]  <= bus.load_y;
            vx_q[bus.load_id] <= bus.load_vx;
            vy_q[bus.load_id] <= bus.load_vy;
          end
        end
        StUpdate: begin
          x_q[idx_q]  <= nx;
          y_q[idx_q]  <= ny;
          vx_q[idx_q] <= nvx;
          vy_q[idx_q] <= nvy;
          if (idx_q == IW'(N_BOTS - 1)) begin
            pi_q    <= '0;
            pj_q    <= IW'(1);
            state_q <= StCollide;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        StCollide: begin
          if (hit) begin
            flag_q[pi_q] <= 1'b1;
            flag_q[pj_q] <= 1'b1;
          end
          if (pj_q == IW'(N_BOTS - 1)) begin
            if (pi_q == IW'(N_BOTS - 2)) begin
              state_q <= StResolve;
            end else begin
              pi_q <= pi_q + IW'(1);
              pj_q <= pi_q + IW'(2);
            end
          end else begin
            pj_q <= pj_q + IW'(1);
          end
        end
        StResolve: begin
          // Flags are per robot, so multi-pair hits still negate only once.
          for (int i = 0; i < N_BOTS; i++) begin
            if (flag_q[i]) begin
              vx_q[i] <= W'(sat(-64'(vx_q[i]), W));
              vy_q[i] <= W'(sat(-64'(vy_q[i]), W));
            end
          end
          state_q <= StDone;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bot_step_sequencer.sv
// Bench for bot_step_sequencer: table vectors, corner sequences and random steps
// checked against a plain-arithmetic model of the robot step.
module tb_bot_step_sequencer;

  localparam int N    = 4;
  localparam int W    = 16;
  localparam int FRAC = 11;
  localparam int TS   = 2048;

  logic clock = 1'b0;
  logic rst_n;

  bot_step_sequencer_if #(.N_BOTS(N), .W(W)) bus ();

  bot_step_sequencer #(.N_BOTS(N), .W(W), .FRAC(FRAC), .T_STEP(TS)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  int mx[N], my[N], mvx[N], mvy[N];
  int mflag;

  typedef struct {
    string name;
    int    x, vx, ax;
    int    ex, evx;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int satw(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  // Reference step: Euler update for all robots, all-pairs sweep, single negation.
  task automatic model_step(input int ax, input int ay, input longint rad);
    longint dx, dy, dsq;
    for (int i = 0; i < N; i++) begin
      mx[i]  = satw(longint'(mx[i]) + ((longint'(mvx[i]) * TS) >>> FRAC));
      my[i]  = satw(longint'(my[i]) + ((longint'(mvy[i]) * TS) >>> FRAC));
      mvx[i] = satw(longint'(mvx[i]) + ((longint'(ax) * TS) >>> FRAC));
      mvy[i] = satw(longint'(mvy[i]) + ((longint'(ay) * TS) >>> FRAC));
    end
    mflag = 0;
    for (int i = 0; i < N; i++) begin
      for (int j = i + 1; j < N; j++) begin
        dx  = longint'(mx[i]) - longint'(mx[j]);
        dy  = longint'(my[i]) - longint'(my[j]);
        dsq = dx * dx + dy * dy;
        if (dsq < rad) mflag = mflag | (1 << i) | (1 << j);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (mflag[i]) begin
        mvx[i] = satw(-longint'(mvx[i]));
        mvy[i] = satw(-longint'(mvy[i]));
      end
    end
  endtask

  task automatic load(input int id, input int x, input int y, input int vx, input int vy);
    @(negedge clock);
    bus.load_valid = 1'b1;
    bus.load_id    = 2'(id);
    bus.load_x     = 16'(x);
    bus.load_y     = 16'(y);
    bus.load_vx    = 16'(vx);
    bus.load_vy    = 16'(vy);
    @(negedge clock);
    bus.load_valid = 1'b0;
    mx[id]  = x;
    my[id]  = y;
    mvx[id] = vx;
    mvy[id] = vy;
  endtask

  // with_load: load_valid alongside start; poke: load/start activity while busy.
  task automatic run_step(input int ax, input int ay, input longint rad,
                          input bit with_load, input bit poke, input bit chk_lat);
    int lat;
    @(negedge clock);
    bus.acc_ax    = 16'(ax);
    bus.acc_ay    = 16'(ay);
    bus.radius_sq = 34'(rad);
    bus.start     = 1'b1;
    if (with_load || poke) begin
      bus.load_id = 2'd3;
      bus.load_x  = 16'sd1234;
      bus.load_y  = -16'sd777;
      bus.load_vx = 16'sd55;
      bus.load_vy = 16'sd66;
    end
    bus.load_valid = with_load;
    @(negedge clock);
    bus.start      = 1'b0;
    bus.load_valid = 1'b0;
    check("busy_after_start", bus.busy, 1);
    lat = 0;
    while (lat < 40 && bus.done !== 1'b1) begin
      if (poke) begin
        bus.load_valid = (lat < 8);
        bus.start      = (lat == 3);
      end
      @(negedge clock);
      lat++;
      if (poke && lat == 2) check("load_ready_while_busy", bus.load_ready, 0);
    end
    bus.load_valid = 1'b0;
    bus.start      = 1'b0;
    check("done_seen", bus.done, 1);
    if (chk_lat) check("done_latency", lat, 12);
    @(negedge clock);
    check("busy_fall", bus.busy, 0);
    check("done_one_cycle", bus.done, 0);
    if (poke) begin
      @(negedge clock);
      check("start_while_busy_ignored", bus.busy, 0);
    end
    model_step(ax, ay, rad);
  endtask

  task automatic compare_all(input string tag);
    for (int i = 0; i < N; i++) begin
      bus.rd_id = 2'(i);
      #1;
      check($sformatf("%s_x%0d", tag, i), bus.rd_x, mx[i]);
      check($sformatf("%s_y%0d", tag, i), bus.rd_y, my[i]);
      check($sformatf("%s_vx%0d", tag, i), bus.rd_vx, mvx[i]);
      check($sformatf("%s_vy%0d", tag, i), bus.rd_vy, mvy[i]);
    end
    check({tag, "_flag"}, bus.coll_flag, mflag);
  endtask

  task automatic read_bot(input int id);
    @(negedge clock);
    bus.rd_id = 2'(id);
    #1;
  endtask

  task automatic park_others();
    load(1, 10000, 10000, 0, 0);
    load(2, -10000, 10000, 0, 0);
    load(3, 10000, -10000, 0, 0);
  endtask

  vec_t vecs[6];

  initial begin
    int seen;
    vecs[0] = '{"basic",      0,      1024,   1024,  1024,   2048};
    vecs[1] = '{"sat_pos",    32000,  16384,  0,     32767,  16384};
    vecs[2] = '{"sat_vel",    0,      32000,  2048,  32000,  32767};
    vecs[3] = '{"sat_neg",    -32000, -16384, -2048, -32768, -18432};
    vecs[4] = '{"plain_neg",  100,    -300,   512,   -200,   212};
    vecs[5] = '{"vel_negsat", 5,      -32768, -1,    -32763, -32768};

    rst_n          = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_id    = '0;
    bus.load_x     = '0;
    bus.load_y     = '0;
    bus.load_vx    = '0;
    bus.load_vy    = '0;
    bus.acc_ax     = '0;
    bus.acc_ay     = '0;
    bus.radius_sq  = '0;
    bus.start      = 1'b0;
    bus.rd_id      = '0;
    for (int i = 0; i < N; i++) begin
      mx[i] = 0; my[i] = 0; mvx[i] = 0; mvy[i] = 0;
    end
    mflag = 0;

    repeat (2) @(negedge clock);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_load_ready", bus.load_ready, 1);
    compare_all("rst");
    rst_n = 1'b1;

    // Single-robot Euler vectors; robots 1..3 parked, radius 0 means no hits.
    park_others();
    for (int k = 0; k < 6; k++) begin
      load(0, vecs[k].x, 0, vecs[k].vx, 0);
      run_step(vecs[k].ax, 0, 0, 1'b0, 1'b0, k == 0);
      read_bot(0);
      check({vecs[k].name, "_x"}, bus.rd_x, vecs[k].ex);
      check({vecs[k].name, "_vx"}, bus.rd_vx, vecs[k].evx);
      check({vecs[k].name, "_flag"}, bus.coll_flag, 0);
    end
    compare_all("vec_end");

    // Two robots moving together end up 205 apart: both bounce.
    load(0, 0, 0, 100, 0);
    load(1, 205, 0, 100, 0);
    load(2, 10000, 10000, 0, 0);
    load(3, -10000, -10000, 0, 0);
    run_step(0, 0, 202500, 1'b0, 1'b0, 1'b1);
    check("coll_pair_flag", bus.coll_flag, 4'b0011);
    read_bot(0);
    check("coll_pair_x0", bus.rd_x, 100);
    check("coll_pair_vx0", bus.rd_vx, -100);
    read_bot(1);
    check("coll_pair_x1", bus.rd_x, 305);
    check("coll_pair_vx1", bus.rd_vx, -100);
    compare_all("coll_pair");

    // dsq exactly at the threshold does not collide; one more does.
    load(0, 0, 0, 0, 0);
    load(1, 300, 400, 0, 0);
    run_step(0, 0, 250000, 1'b0, 1'b0, 1'b0);
    check("eq_radius_flag", bus.coll_flag, 0);
    run_step(0, 0, 250001, 1'b0, 1'b0, 1'b0);
    check("above_radius_flag", bus.coll_flag, 4'b0011);

    // Robot 0 sits in two colliding pairs; negated once.
    load(0, 0, 0, 5, 7);
    load(1, 10, 0, 0, 0);
    load(2, -10, 0, 0, 0);
    run_step(0, 0, 10000, 1'b0, 1'b0, 1'b0);
    check("multi_flag", bus.coll_flag, 4'b0111);
    read_bot(0);
    check("multi_vx0", bus.rd_vx, -5);
    check("multi_vy0", bus.rd_vy, -7);
    compare_all("multi");

    // Negating the most negative velocity saturates.
    load(0, 32767, 0, -32768, 0);
    load(1, 0, 0, 0, 0);
    load(2, 10000, 10000, 0, 0);
    run_step(0, 0, 100, 1'b0, 1'b0, 1'b0);
    read_bot(0);
    check("negsat_x0", bus.rd_x, -1);
    check("negsat_vx0", bus.rd_vx, 32767);
    check("negsat_flag", bus.coll_flag, 4'b0011);

    // Handshake: start beats a same-cycle load; loads and start while busy ignored.
    run_step(10, -10, 0, 1'b1, 1'b0, 1'b0);
    compare_all("start_vs_load");
    run_step(-20, 30, 400, 1'b0, 1'b1, 1'b1);
    compare_all("busy_poke");

    // Random steps against the model, alternating small and full-range values.
    for (int it = 0; it < 10; it++) begin
      for (int i = 0; i < N; i++) begin
        if (it % 2 == 0) begin
          load(i, int'($urandom_range(4000)) - 2000, int'($urandom_range(4000)) - 2000,
               int'($urandom_range(6000)) - 3000, int'($urandom_range(6000)) - 3000);
        end else begin
          load(i, int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768,
               int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768);
        end
      end
      run_step(int'($urandom_range(2000)) - 1000, int'($urandom_range(2000)) - 1000,
               longint'($urandom_range(4000000)), 1'b0, 1'b0, 1'b0);
      compare_all($sformatf("rand%0d", it));
    end

    // Reset during COLLIDE: everything clears and no done ever follows.
    load(0, 0, 0, 100, 0);
    load(1, 205, 0, 100, 0);
    @(negedge clock);
    bus.radius_sq = 34'd202500;
    bus.start     = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (6) @(negedge clock);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      mx[i] = 0; my[i] = 0; mvx[i] = 0; mvy[i] = 0;
    end
    mflag = 0;
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_load_ready", bus.load_ready, 1);
    compare_all("midrst");
    @(negedge clock);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
    end
    check("midrst_no_done", seen, 0);
    compare_all("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
